// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receive FIFO and its neighbours: receiver byte
// strobe and data, the bus-side pop port, and the interrupt/status outputs.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rd_en;
  logic          ien;
  logic          ack;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overrun;
  logic          irq;

  modport master (
    output rx_data, rx_valid, rd_en, ien, ack,
    input  rd_data, empty, full, count, overrun, irq
  );

  modport slave (
    input  rx_data, rx_valid, rd_en, ien, ack,
    output rd_data, empty, full, count, overrun, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind a UART receiver: captures one byte per rising
// edge of rx_valid, exposes a show-ahead pop port and a sticky threshold/overrun irq.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_rx_fifo_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          valid_q;
  logic          overrun_q;
  logic          irq_q;
  logic          is_empty;
  logic          is_full;
  logic          push_req;
  logic          pop_ok;
  logic          push_ok;
  logic          drop;
  logic          irq_set;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    push_req  = bus.rx_valid & ~valid_q;
    pop_ok    = bus.rd_en & ~is_empty;
    push_ok   = push_req & (~is_full | pop_ok);
    drop      = push_req & is_full & ~pop_ok;
    count_nxt = count_q;
    if (push_ok && !pop_ok)
      count_nxt = count_q + CW'(1);
    else if (pop_ok && !push_ok)
      count_nxt = count_q - CW'(1);
    // Threshold is judged on the occupancy that results from this edge.
    irq_set = bus.ien & ((push_ok & (count_nxt >= CW'(THRESHOLD))) | drop);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b1;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      valid_q <= bus.rx_valid;
      count_q <= count_nxt;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      // Set beats ack so an event landing on the ack cycle is not lost.
      if (drop)         overrun_q <= 1'b1;
      else if (bus.ack) overrun_q <= 1'b0;
      if (irq_set)      irq_q <= 1'b1;
      else if (bus.ack) irq_q <= 1'b0;
    end
  end

  // NOTE: storage is deliberately left out of reset; occupancy and pointers
  // alone decide what is valid, and this keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.rx_data;
  end

  assign bus.rd_data = is_empty ? 8'h00 : mem[rd_ptr];
  assign bus.empty   = is_empty;
  assign bus.full    = is_full;
  assign bus.count   = count_q;
  assign bus.overrun = overrun_q;
  assign bus.irq     = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: two instances (THRESHOLD 1 and 4) share one stimulus
// stream and are compared against a queue-based model every checked cycle.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = CW + 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b1;
  logic       rd_en = 1'b0;
  logic       ien = 1'b0;
  logic       ack = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) if1 ();
  uart_rx_fifo_if #(.DEPTH(DEPTH)) if4 ();

  assign if1.rx_data = rx_data;  assign if4.rx_data = rx_data;
  assign if1.rx_valid = rx_valid; assign if4.rx_valid = rx_valid;
  assign if1.rd_en = rd_en;      assign if4.rd_en = rd_en;
  assign if1.ien = ien;          assign if4.ien = ien;
  assign if1.ack = ack;          assign if4.ack = ack;

  uart_rx_fifo #(.DEPTH(DEPTH), .THRESHOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  uart_rx_fifo #(.DEPTH(DEPTH), .THRESHOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  logic [OW-1:0] obs [2];
  assign obs[0] = {if1.count, if1.empty, if1.full, if1.overrun, if1.irq, if1.rd_data};
  assign obs[1] = {if4.count, if4.empty, if4.full, if4.overrun, if4.irq, if4.rd_data};

  // Reference model: a byte queue plus sticky flags, one irq per threshold.
  logic [7:0] q [$];
  logic       prev_valid = 1'b1;
  logic       m_ovr = 1'b0;
  logic       m_irq [2] = '{1'b0, 1'b0};
  int         th [2] = '{1, 4};

  function automatic void model_step();
    bit push, popped, pushed, dropped;
    if (rst) begin
      q.delete();
      prev_valid = 1'b1;
      m_ovr = 1'b0;
      m_irq[0] = 1'b0;
      m_irq[1] = 1'b0;
      return;
    end
    push = rx_valid && !prev_valid;
    prev_valid = rx_valid;
    popped = rd_en && (q.size() > 0);
    pushed = 1'b0;
    dropped = 1'b0;
    if (popped) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) begin
        q.push_back(rx_data);
        pushed = 1'b1;
      end else begin
        dropped = 1'b1;
      end
    end
    if (dropped) m_ovr = 1'b1;
    else if (ack) m_ovr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (ien && ((pushed && q.size() >= th[d]) || dropped)) m_irq[d] = 1'b1;
      else if (ack) m_irq[d] = 1'b0;
    end
  endfunction

  function automatic logic [OW-1:0] exp_vec(int d);
    logic [7:0] head;
    head = (q.size() > 0) ? q[0] : 8'h00;
    return {CW'(q.size()), q.size() == 0, q.size() == DEPTH, m_ovr, m_irq[d], head};
  endfunction

  // Inputs change at the falling edge; the model advances with the rising edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic pop, input logic do_ack);
    rx_data = b; rx_valid = 1'b1; rd_en = pop; ack = do_ack;
    cycle();
    rx_valid = 1'b0; rd_en = 1'b0; ack = 1'b0;
    cycle();
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs[d] !== exp_vec(d)) begin
          miscompares++;
          $display("FAIL reset_hold c=%0d thr=%0d got=%h exp=%h", c, th[d], obs[d], exp_vec(d));
        end
      end
    end
    vectors++;
    if (if1.count !== '0 || if1.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_no_push got count=%0d empty=%b exp count=0 empty=1", if1.count, if1.empty);
    end
    rx_valid = 1'b0;
    cycle();
  endtask

  task automatic test_single();
    ien = 1'b1;
    push_byte(8'hA5, 1'b0, 1'b0);
    vectors++;
    if (if1.rd_data !== 8'hA5 || if1.irq !== 1'b1 || if1.count !== CW'(1)) begin
      miscompares++;
      $display("FAIL single_push got data=%h irq=%b count=%0d exp data=a5 irq=1 count=1",
               if1.rd_data, if1.irq, if1.count);
    end
    ack = 1'b1; cycle(); ack = 1'b0;
    pop_one();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (obs[d] !== exp_vec(d)) begin
        miscompares++;
        $display("FAIL single_ack_pop thr=%0d got=%h exp=%h", th[d], obs[d], exp_vec(d));
      end
    end
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < DEPTH + 1; i++) begin
      push_byte((i == DEPTH) ? 8'hFF : 8'(i), 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs[d] !== exp_vec(d)) begin
          miscompares++;
          $display("FAIL fill i=%0d thr=%0d got=%h exp=%h", i, th[d], obs[d], exp_vec(d));
        end
      end
    end
    vectors++;
    if (if4.full !== 1'b1 || if4.overrun !== 1'b1 || if4.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_flags got full=%b ovr=%b irq=%b exp 1 1 1", if4.full, if4.overrun, if4.irq);
    end
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (if1.rd_data !== 8'(i)) begin
        miscompares++;
        $display("FAIL drain_order i=%0d got=%h exp=%h", i, if1.rd_data, 8'(i));
      end
      pop_one();
    end
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (obs[d] !== exp_vec(d)) begin
        miscompares++;
        $display("FAIL drained thr=%0d got=%h exp=%h", th[d], obs[d], exp_vec(d));
      end
    end
  endtask

  task automatic test_full_simul();
    ack = 1'b1; cycle(); ack = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i), 1'b0, 1'b0);
    push_byte(8'h77, 1'b1, 1'b0);
    vectors++;
    if (if1.count !== CW'(DEPTH) || if1.overrun !== 1'b0 || if1.rd_data !== 8'h11) begin
      miscompares++;
      $display("FAIL full_push_pop got count=%0d ovr=%b head=%h exp count=16 ovr=0 head=11",
               if1.count, if1.overrun, if1.rd_data);
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs[d] !== exp_vec(d)) begin
          miscompares++;
          $display("FAIL full_drain i=%0d thr=%0d got=%h exp=%h", i, th[d], obs[d], exp_vec(d));
        end
      end
      if (i == DEPTH - 1) begin
        vectors++;
        if (if4.rd_data !== 8'h77) begin
          miscompares++;
          $display("FAIL tail_byte got=%h exp=77", if4.rd_data);
        end
      end
      pop_one();
    end
  endtask

  task automatic test_empty_simul_wrap();
    push_byte(8'h3C, 1'b1, 1'b0);
    vectors++;
    if (if1.count !== CW'(1) || if1.rd_data !== 8'h3C) begin
      miscompares++;
      $display("FAIL empty_push_pop got count=%0d data=%h exp count=1 data=3c", if1.count, if1.rd_data);
    end
    pop_one();
    for (int i = 0; i < 20; i++) begin
      push_byte(8'($urandom), 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs[d] !== exp_vec(d)) begin
          miscompares++;
          $display("FAIL wrap_push i=%0d thr=%0d got=%h exp=%h", i, th[d], obs[d], exp_vec(d));
        end
      end
      pop_one();
    end
  endtask

  task automatic test_threshold();
    rst = 1'b1; cycle(); rst = 1'b0; rx_valid = 1'b0; cycle();
    ien = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_byte(8'(8'h40 + i), 1'b0, i == 4);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs[d] !== exp_vec(d)) begin
          miscompares++;
          $display("FAIL threshold i=%0d thr=%0d got=%h exp=%h", i, th[d], obs[d], exp_vec(d));
        end
      end
      vectors++;
      if (if4.irq !== (i >= 3)) begin
        miscompares++;
        $display("FAIL thr4_irq i=%0d got=%b exp=%b", i, if4.irq, i >= 3);
      end
    end
    ack = 1'b1; cycle(); ack = 1'b0;
    ien = 1'b0;
    for (int i = 0; i < DEPTH - 4; i++) push_byte(8'($urandom), 1'b0, 1'b0);
    vectors++;
    if (if4.overrun !== 1'b1 || if4.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL ien_low_overrun got ovr=%b irq=%b exp ovr=1 irq=0", if4.overrun, if4.irq);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(63) == 0);
      rx_valid = $urandom_range(1);
      rx_data  = 8'($urandom);
      rd_en    = ($urandom_range(2) == 0);
      ien      = ($urandom_range(3) != 0);
      ack      = ($urandom_range(7) == 0);
      cycle();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs[d] !== exp_vec(d)) begin
          miscompares++;
          $display("FAIL random c=%0d thr=%0d got=%h exp=%h", c, th[d], obs[d], exp_vec(d));
        end
      end
    end
    rst = 1'b0; ack = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_fill_overrun();
    test_full_simul();
    test_empty_simul_wrap();
    test_threshold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
